// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Wide enough for any practical DATA_W; users slice the low DATA_W/8 bits.
    localparam logic [127:0] MASK_ALL = '1;

    // A lone requester wins; on a tie the requester that did not win last time goes.
    function automatic owner_e pick_winner(input logic i_req, input logic d_req,
                                           input owner_e last);
        if (i_req && d_req) return (last == OWN_I) ? OWN_D : OWN_I;
        if (d_req)          return OWN_D;
        return OWN_I;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Unified memory bus between the arbiter (master) and the memory wrapper (slave).
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              mem_request;
    logic              mem_we_re;
    logic [MASK_W-1:0] mem_mask;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (
        output mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid
    );

    modport slave (
        input  mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
        output mem_rdata, mem_valid
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Counts grant cycles without a bus response; expired flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_disabled
        assign expired = 1'b0;
    end else begin : g_enabled
        localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

        logic [CNT_W-1:0] count;

        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                count <= '0;
            end else if (enable) begin
                count <= count + 1'b1;
            end
        end

        assign expired = (count == LAST);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory bus, one transaction at a time.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_request,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,

    input  logic                d_request,
    input  logic                d_we_re,
    input  logic [DATA_W/8-1:0] d_mask,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,

    mem_bus_arbiter_if.master   mem,

    output logic                err
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    owner_e            last_q, last_d;
    owner_e            winner;
    logic              done;
    logic              cnt_clear, cnt_enable, expired;
    logic [DATA_W-1:0] resp_data;

    logic              req_d, we_d;
    logic [MASK_W-1:0] mask_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_q          <= OWN_I;
            mem.mem_request <= 1'b0;
            mem.mem_we_re   <= 1'b0;
            mem.mem_mask    <= '0;
            mem.mem_addr    <= '0;
            mem.mem_wdata   <= '0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            mem.mem_request <= req_d;
            mem.mem_we_re   <= we_d;
            mem.mem_mask    <= mask_d;
            mem.mem_addr    <= addr_d;
            mem.mem_wdata   <= wdata_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        last_d     = last_q;
        winner     = OWN_I;
        done       = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        resp_data  = '0;
        req_d      = 1'b0;
        we_d       = 1'b0;
        mask_d     = '0;
        addr_d     = '0;
        wdata_d    = '0;
        i_valid    = 1'b0;
        i_rdata    = '0;
        d_valid    = 1'b0;
        d_rdata    = '0;
        err        = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (i_request || d_request) begin
                    winner = pick_winner(i_request, d_request, last_q);
                    last_d = winner;
                    req_d  = 1'b1;
                    if (winner == OWN_D) begin
                        state_d = GRANT_D;
                        we_d    = d_we_re;
                        mask_d  = d_mask;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = GRANT_I;
                        mask_d  = MASK_ALL[MASK_W-1:0];
                        addr_d  = i_addr;
                    end
                end
            end

            GRANT_I, GRANT_D: begin
                // A response in the expiry cycle wins over the timeout.
                done      = mem.mem_valid || expired;
                resp_data = mem.mem_valid ? mem.mem_rdata : '0;
                if (done) begin
                    state_d = IDLE;
                    // A reset edge abandons the transaction silently.
                    if (!rst) begin
                        err = !mem.mem_valid;
                        if (state_q == GRANT_I) begin
                            i_valid = 1'b1;
                            i_rdata = resp_data;
                        end else begin
                            d_valid = 1'b1;
                            d_rdata = resp_data;
                        end
                    end
                end else begin
                    cnt_enable = 1'b1;
                    req_d      = 1'b1;
                    we_d       = mem.mem_we_re;
                    mask_d     = mem.mem_mask;
                    addr_d     = mem.mem_addr;
                    wdata_d    = mem.mem_wdata;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter with a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_request, i_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_request, d_we_re, d_valid;
    logic [MW-1:0] d_mask;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_request (i_request),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_valid   (i_valid),
        .d_request (d_request),
        .d_we_re   (d_we_re),
        .d_mask    (d_mask),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem       (mem_if.master),
        .err       (err)
    );

    // Reference model: who holds the bus, for how long, and what it asked for.
    bit          m_busy;
    bit          m_own;      // 0 = fetch, 1 = data
    bit          m_last;
    int          m_age;
    int          m_delay;
    bit          m_fire, m_fire_i, m_fire_d;
    bit          m_we;
    logic [MW-1:0] m_mask;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_last = 0; m_age = 0;
        m_we = 0; m_mask = '0; m_addr = '0; m_wdata = '0;
    endtask

    // Compare all outputs against the model at the falling edge.
    task automatic sample();
        bit timeout;
        @(negedge clk);
        timeout  = (m_age == TO - 1);
        m_fire   = m_busy && !rst && (mem_if.mem_valid || timeout);
        m_fire_i = m_fire && !m_own;
        m_fire_d = m_fire && m_own;
        check("mem_request", mem_if.mem_request, m_busy);
        check("mem_we_re",   mem_if.mem_we_re,   m_busy ? m_we    : 1'b0);
        check("mem_mask",    mem_if.mem_mask,    m_busy ? m_mask  : '0);
        check("mem_addr",    mem_if.mem_addr,    m_busy ? m_addr  : '0);
        check("mem_wdata",   mem_if.mem_wdata,   m_busy ? m_wdata : '0);
        check("i_valid",     i_valid,            m_fire_i);
        check("d_valid",     d_valid,            m_fire_d);
        check("i_rdata",     i_rdata,            (m_fire_i && mem_if.mem_valid) ? mem_if.mem_rdata : '0);
        check("d_rdata",     d_rdata,            (m_fire_d && mem_if.mem_valid) ? mem_if.mem_rdata : '0);
        check("err",         err,                m_fire && !mem_if.mem_valid);
    endtask

    // Move the model to the next cycle, then step to just after the rising edge.
    task automatic advance();
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (i_request || d_request) begin
                m_own   = (i_request && d_request) ? !m_last : d_request;
                m_last  = m_own;
                m_busy  = 1;
                m_age   = 0;
                m_delay = $urandom_range(0, 5);
                if (m_own) begin
                    m_we = d_we_re; m_mask = d_mask; m_addr = d_addr; m_wdata = d_wdata;
                end else begin
                    m_we = 0; m_mask = '1; m_addr = i_addr; m_wdata = '0;
                end
            end
        end else if (m_fire) begin
            m_busy = 0;
        end else begin
            m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    int d_pulses;

    initial begin
        rst = 1; i_request = 0; i_addr = '0; d_request = 0; d_we_re = 0;
        d_mask = '0; d_addr = '0; d_wdata = '0;
        mem_if.mem_valid = 0; mem_if.mem_rdata = '0;
        model_reset();
        @(posedge clk); #1;

        // Reset state.
        sample();
        check("rst_mem_request", mem_if.mem_request, 1'b0);
        check("rst_mem_addr", mem_if.mem_addr, 32'h0);
        check("rst_valids", {i_valid, d_valid, err}, 3'b000);
        advance();

        // Fetch only, answered in the first grant cycle.
        rst = 0; i_request = 1; i_addr = 32'h100;
        sample(); advance();
        mem_if.mem_valid = 1; mem_if.mem_rdata = 32'h0000_0013;
        sample();
        check("fetch_i_valid", i_valid, 1'b1);
        check("fetch_i_rdata", i_rdata, 32'h13);
        check("fetch_mask", mem_if.mem_mask, 4'hF);
        check("fetch_we", mem_if.mem_we_re, 1'b0);
        check("fetch_addr", mem_if.mem_addr, 32'h100);
        advance();
        i_request = 0; mem_if.mem_valid = 0;
        sample();
        check("fetch_bubble", mem_if.mem_request, 1'b0);
        advance();

        // Ties after reset alternate data, fetch, data.
        rst = 1; sample(); advance();
        rst = 0; i_request = 1; i_addr = 32'h200;
        d_request = 1; d_we_re = 0; d_addr = 32'h40; d_mask = 4'hF;
        sample(); advance();
        mem_if.mem_valid = 1; mem_if.mem_rdata = 32'hAA;
        sample();
        check("tie1_d_valid", d_valid, 1'b1);
        check("tie1_i_valid", i_valid, 1'b0);
        check("tie1_addr", mem_if.mem_addr, 32'h40);
        advance();
        mem_if.mem_valid = 0; sample(); advance();
        mem_if.mem_valid = 1; mem_if.mem_rdata = 32'hBB;
        sample();
        check("tie2_i_valid", i_valid, 1'b1);
        check("tie2_addr", mem_if.mem_addr, 32'h200);
        advance();
        mem_if.mem_valid = 0; sample(); advance();
        mem_if.mem_valid = 1;
        sample();
        check("tie3_d_valid", d_valid, 1'b1);
        check("tie3_addr", mem_if.mem_addr, 32'h40);
        advance();
        i_request = 0; d_request = 0; mem_if.mem_valid = 0;
        sample(); advance();

        // Store held for 3 wait cycles; the answer lands in the timeout cycle and wins.
        d_request = 1; d_we_re = 1; d_mask = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
        sample(); advance();
        d_pulses = 0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("store_addr", mem_if.mem_addr, 32'h2004);
            check("store_wdata", mem_if.mem_wdata, 32'hDEAD_BEEF);
            check("store_mask_we", {mem_if.mem_mask, mem_if.mem_we_re}, 5'b0011_1);
            d_pulses += int'(d_valid);
            advance();
        end
        mem_if.mem_valid = 1; mem_if.mem_rdata = 32'h1234_5678;
        sample();
        d_pulses += int'(d_valid);
        check("store_d_rdata", d_rdata, 32'h1234_5678);
        check("store_err", err, 1'b0);
        check("store_pulses", d_pulses, 1);
        advance();
        d_request = 0; mem_if.mem_valid = 0;
        sample(); advance();

        // Load that never gets an answer times out in the 4th grant cycle.
        d_request = 1; d_we_re = 0; d_mask = 4'hF; d_addr = 32'h3000;
        mem_if.mem_rdata = 32'hFFFF_FFFF;
        sample(); advance();
        for (int k = 0; k < 3; k++) begin
            sample();
            check("to_wait_d_valid", d_valid, 1'b0);
            advance();
        end
        sample();
        check("to_d_valid", d_valid, 1'b1);
        check("to_err", err, 1'b1);
        check("to_d_rdata", d_rdata, 32'h0);
        advance();
        d_request = 0;
        sample();
        check("to_after_req", mem_if.mem_request, 1'b0);
        advance();

        // Reset in the second cycle of a data grant while a fetch waits.
        d_request = 1; d_addr = 32'h4000;
        sample(); advance();
        i_request = 1; i_addr = 32'h500;
        sample(); advance();
        rst = 1;
        sample();
        check("rstmid_valids", {i_valid, d_valid}, 2'b00);
        advance();
        rst = 0;
        sample();
        check("rstmid_req", mem_if.mem_request, 1'b0);
        check("rstmid_outs", {i_valid, d_valid, err, mem_if.mem_addr}, 35'h0);
        advance();
        mem_if.mem_valid = 1;
        sample();
        check("rstmid_tie_addr", mem_if.mem_addr, 32'h4000);
        check("rstmid_tie_d", d_valid, 1'b1);
        advance();
        i_request = 0; d_request = 0; mem_if.mem_valid = 0;
        sample(); advance();

        // Random traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (i_request && m_fire_i) begin
                if ($urandom_range(0, 1) == 1) i_addr = $urandom;
                else i_request = 0;
            end else if (!i_request && $urandom_range(0, 3) == 0) begin
                i_request = 1; i_addr = $urandom;
            end
            if (d_request && m_fire_d) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_addr = $urandom; d_wdata = $urandom;
                    d_we_re = 1'($urandom_range(0, 1)); d_mask = 4'($urandom);
                end else begin
                    d_request = 0;
                end
            end else if (!d_request && $urandom_range(0, 3) == 0) begin
                d_request = 1; d_addr = $urandom; d_wdata = $urandom;
                d_we_re = 1'($urandom_range(0, 1)); d_mask = 4'($urandom);
            end
            mem_if.mem_valid = m_busy ? (m_age == m_delay) : ($urandom_range(0, 3) == 0);
            mem_if.mem_rdata = $urandom;
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single unified memory bus between the instruction-fetch requester and the load/store requester driven by the memory stage. The arbiter accepts one transaction at a time, captures the winning request, drives the bus until `mem_valid` returns or a timeout expires, and routes the response back to its owner. It sits between the core (fetch unit and memory stage) and the memory wrapper.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; the mask width is `DATA_W/8`.
- `TIMEOUT`, 64: number of grant cycles without `mem_valid` before the transaction is forcibly ended. Legal range is 2..65535; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_request` in 1: fetch request; held high until its `i_valid` cycle.
- `i_addr` in ADDR_W: fetch address.
- `i_rdata` out DATA_W: fetch read data; valid only when `i_valid` is high, otherwise 0.
- `i_valid` out 1: one-cycle fetch response pulse.
- `d_request` in 1: data request (`load | store`); held high until its `d_valid` cycle.
- `d_we_re` in 1: 1 = store, 0 = load.
- `d_mask` in DATA_W/8: byte-enable mask.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data; valid only when `d_valid` is high, otherwise 0.
- `d_valid` out 1: one-cycle data response pulse.
- `mem_request` out 1: bus request.
- `mem_we_re` out 1: bus write enable.
- `mem_mask` out DATA_W/8: bus byte mask.
- `mem_addr` out ADDR_W: bus address.
- `mem_wdata` out DATA_W: bus write data.
- `mem_rdata` in DATA_W: bus read data.
- `mem_valid` in 1: bus response, sampled only while a grant is active.
- `err` out 1: one-cycle pulse on timeout.

## Operation
- **States:** `IDLE`, `GRANT_I`, `GRANT_D`. A register `last` records the most recent grant and resets to fetch.
- **In `IDLE`:**
  - One request pending: that requester wins.
  - Both pending: the requester not equal to `last` wins, so the first tie after reset goes to data.
  - At the clock edge the winner's fields are captured, the state moves to `GRANT_x`, `last` is updated and the timeout counter clears.
- **Registered bus fields during a grant:**
  - Fetch grant: `mem_we_re=0`, `mem_mask=all ones`, `mem_wdata=0`.
  - Data grant: the captured `d_we_re`, `d_mask` and `d_wdata`.
- **In `GRANT_x`:**
  - `mem_request=1`.
  - Request-line and field changes are ignored; changing them mid-grant is illegal.
  - Non-owner requests wait.
- **Response:**
  - When `mem_valid=1` in `GRANT_x`, the owner's `x_valid=1` and `x_rdata=mem_rdata` combinationally in the same cycle.
  - The next state is `IDLE`.
  - For stores, `d_rdata` passes `mem_rdata` unchanged.
- **Timeout:**
  - The counter increments each `GRANT_x` cycle that has `mem_valid=0`.
  - If the counter equals `TIMEOUT-1` and `mem_valid=0`, that cycle produces `x_valid=1`, `x_rdata=0`, `err=1`, and the next state is `IDLE`.
  - If `mem_valid` arrives in that same cycle, it wins and `err` stays 0.
- **Idle outputs:** `mem_*` outputs are 0 whenever the state is `IDLE`.

## Timing
- **Reset values:**
  - State `IDLE`, `last`=fetch, counter 0.
  - All `mem_*` outputs 0.
  - `i_valid`, `d_valid`, `err` = 0; `i_rdata`, `d_rdata` = 0.
- **Reset mid-grant:** the transaction is abandoned with no response pulse, and `mem_request` is 0 in the first cycle after the reset edge.
- **Latency:** request high in cycle 0 (`IDLE`) → `mem_request` high in cycle 1 → earliest response in cycle 1 (when `mem_valid` is in cycle 1) → `IDLE` in cycle 2.
- **Throughput:** a mandatory `IDLE` bubble follows every transaction, so the peak rate is one transaction per 2 cycles.
- **Handshake rule:** a request line still high in the cycle after its valid pulse counts as a new transaction.
- **Response path:** combinational from `mem_valid`/`mem_rdata` and state.
- **Registered outputs:** `mem_*` are driven from registers only.

## Structure
- **Package `mem_arb_pkg`:**
  - State enum (`IDLE`, `GRANT_I`, `GRANT_D`).
  - Owner encoding (`OWN_I=0`, `OWN_D=1`).
  - `MASK_ALL` constant.
- **Sub-module `mem_timeout_counter`:**
  - Ports: `clk`, `rst`, `clear`, `enable`, `expired`.
  - Parameterised by `TIMEOUT`, with counter width `$clog2(TIMEOUT)`.
  - Ties `expired=0` when `TIMEOUT=0`.

## Test plan
- Fetch only: `i_addr=0x100`, `mem_valid` in the first grant cycle with `mem_rdata=0x00000013` → `i_valid` in cycle 1 carrying 0x13, `mem_mask=4'hF`, `mem_we_re=0`.
- Simultaneous `i_request` and `d_request` after reset → data granted first; fetch granted in the next `IDLE`; a third tie with both held goes to data again (alternation).
- Store: `d_addr=0x2004`, `d_mask=4'b0011`, `d_wdata=0xDEADBEEF`, with a 3-cycle bus delay → `mem_*` fields stay stable for 3 cycles; `d_valid` pulses once, in the `mem_valid` cycle.
- `TIMEOUT=4`, `mem_valid` never returns → `d_valid=1`, `err=1`, `d_rdata=0` in the 4th grant cycle; `mem_request` low the next cycle.
- `rst` asserted in the second cycle of a pending grant → no `x_valid`; all outputs 0 on the following cycle; a pending fetch is re-arbitrated with `last`=fetch, so a tie goes to data.
- `mem_valid` arriving exactly in the timeout cycle → normal response, `err=0`.
